// File: rtl/adv_pixel_packer_if.sv
// adv_pixel_packer_if: decoder byte stream in, packed 32-bit capture FIFO words out.
interface adv_pixel_packer_if;
  logic [7:0]  vid_data;
  logic        vid_vs;
  logic        vid_de;
  logic        fifo_full;
  logic [31:0] word_out;
  logic        word_wr;
  modport master (input vid_data, vid_vs, vid_de, fifo_full, output word_out, word_wr);
  modport slave (output vid_data, vid_vs, vid_de, fifo_full, input word_out, word_wr);
endinterface

// File: rtl/adv_pixel_packer.sv
// adv_pixel_packer: frame-gated packing of ADV decoder bytes into 32-bit FIFO words,
// with line-end flush, line counting and drop accounting.
module adv_pixel_packer #(
  parameter int         LINE_CNT_W     = 11,
  parameter int         DROP_CNT_W     = 16,
  parameter logic [7:0] PAD_BYTE       = 8'h00,
  parameter bit         VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                  pix_clk,
  input  logic                  rst_n,
  input  logic                  capture_en,
  adv_pixel_packer_if.master    bus,
  output logic                  frame_start,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  overflow,
  output logic                  capturing
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_e;
  state_e                state_q, state_d;
  logic [7:0]            data_q;
  logic                  vs_q, de_q, vs_p, de_p, cap_q;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           wbuf_q, wbuf_d, flush_word;
  logic                  pend_q, pend_d;
  logic [31:0]           pword_q, pword_d, word_q, word_d;
  logic                  wr_q, wr_d, fs_q, fs_d, ov_q, ov_d;
  logic [LINE_CNT_W-1:0] lc_q, lc_d;
  logic [DROP_CNT_W-1:0] dc_q, dc_d;
  logic                  vs_edge, de_fall, active, start, pack, flush, drop, cap_rise;
  assign vs_edge  = VS_ACTIVE_HIGH ? (vs_q && !vs_p) : (!vs_q && vs_p);
  assign de_fall  = de_p && !de_q;
  assign active   = state_q == ACTIVE;
  assign start    = vs_edge && capture_en && state_q != IDLE;
  assign pack     = active && de_q && !vs_edge;
  assign flush    = active && de_fall && idx_q != 2'd0;
  assign drop     = pend_q && bus.fifo_full;
  assign cap_rise = capture_en && !cap_q;
  always_comb begin
    state_d = state_q == IDLE ? (capture_en ? WAIT_VS : IDLE) :
              state_q == WAIT_VS ? (!capture_en ? IDLE : vs_edge ? ACTIVE : WAIT_VS) :
              (vs_edge && !capture_en) ? IDLE : ACTIVE;
    wbuf_d     = wbuf_q;
    flush_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (pack && idx_q == 2'(i)) wbuf_d[31-8*i -: 8] = data_q;
      flush_word[31-8*i -: 8] = (2'(i) < idx_q) ? wbuf_q[31-8*i -: 8] : PAD_BYTE;
    end
    // A VS edge discards the partial word; a line end in the same cycle still flushes first.
    idx_d   = (!active || vs_edge || flush) ? 2'd0 : pack ? idx_q + 2'd1 : idx_q;
    pend_d  = (pack && idx_q == 2'd3) || flush;
    pword_d = flush ? flush_word : {wbuf_q[31:8], data_q};
    lc_d    = start ? '0 : (active && de_fall) ? lc_q + 1'b1 : lc_q;
    fs_d    = start;
    wr_d    = pend_q && !bus.fifo_full;
    word_d  = wr_d ? pword_q : word_q;
    dc_d    = cap_rise ? '0 : (drop && !(&dc_q)) ? dc_q + 1'b1 : dc_q;
    ov_d    = cap_rise ? 1'b0 : ov_q || drop;
  end
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      vs_p    <= 1'b0;
      de_p    <= 1'b0;
      cap_q   <= 1'b0;
      idx_q   <= '0;
      wbuf_q  <= '0;
      pend_q  <= 1'b0;
      pword_q <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      fs_q    <= 1'b0;
      lc_q    <= '0;
      dc_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= bus.vid_data;
      vs_q    <= bus.vid_vs;
      de_q    <= bus.vid_de;
      vs_p    <= vs_q;
      de_p    <= de_q;
      cap_q   <= capture_en;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      pend_q  <= pend_d;
      pword_q <= pword_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      fs_q    <= fs_d;
      lc_q    <= lc_d;
      dc_q    <= dc_d;
      ov_q    <= ov_d;
    end
  end
  assign bus.word_out = word_q;
  assign bus.word_wr  = wr_q;
  assign frame_start  = fs_q;
  assign line_count   = lc_q;
  assign drop_count   = dc_q;
  assign overflow     = ov_q;
  assign capturing    = active;
endmodule

// File: tb/tb_adv_pixel_packer.sv
// tb_adv_pixel_packer: directed and randomized line/frame stimulus checked against a
// line-level model that chops each line into padded 4-byte words.
module tb_adv_pixel_packer;
  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        frame_start, overflow, capturing;
  logic [10:0] line_count;
  logic [15:0] drop_count;
  int          checks = 0, errors = 0, fs_cnt = 0;
  int          exp_fs = 0, exp_lc = 0, exp_dc = 0;
  logic        exp_ov = 1'b0;
  logic [7:0]  line_q[$];
  logic [31:0] got_q[$], exp_q[$];
  adv_pixel_packer_if bus();
  adv_pixel_packer dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .capture_en(capture_en), .bus(bus),
    .frame_start(frame_start), .line_count(line_count), .drop_count(drop_count),
    .overflow(overflow), .capturing(capturing)
  );
  always #5 pix_clk = ~pix_clk;
  always @(negedge pix_clk) begin
    if (bus.word_wr) got_q.push_back(bus.word_out);
    if (frame_start) fs_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic vs, input logic de);
    @(negedge pix_clk);
    bus.vid_data = d;
    bus.vid_vs   = vs;
    bus.vid_de   = de;
  endtask
  task automatic vs_pulse();
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b0);
  endtask
  // Drives line_q with DE high, then a DE-low gap; cap says whether words are expected.
  task automatic run_line(input logic full, input logic cap);
    int n;
    logic [31:0] w;
    n = line_q.size();
    bus.fifo_full = full;
    foreach (line_q[i]) step(line_q[i], 1'b0, 1'b1);
    repeat (6) step(8'h00, 1'b0, 1'b0);
    if (cap) begin
      exp_lc++;
      for (int k = 0; k < n; k += 4) begin
        w = '0;
        for (int j = 0; j < 4; j++) if (k + j < n) w[31-8*j -: 8] = line_q[k+j];
        if (full) begin
          exp_dc++;
          exp_ov = 1'b1;
        end else exp_q.push_back(w);
      end
    end
    bus.fifo_full = 1'b0;
  endtask
  task automatic rand_line(input int len);
    line_q = {};
    for (int i = 0; i < len; i++) line_q.push_back(8'($urandom_range(1, 255)));
  endtask
  task automatic check_words(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q = {};
    exp_q = {};
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_frame_start_cnt"}, fs_cnt, exp_fs);
    chk({tag, "_line_count"}, line_count, exp_lc);
    chk({tag, "_drop_count"}, drop_count, exp_dc);
    chk({tag, "_overflow"}, overflow, exp_ov);
  endtask
  initial begin
    bus.vid_data = '0; bus.vid_vs = 1'b0; bus.vid_de = 1'b0; bus.fifo_full = 1'b0;
    repeat (3) @(negedge pix_clk);
    chk("rst_word_out", bus.word_out, 0);
    chk("rst_word_wr", bus.word_wr, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_capturing", capturing, 0);
    rst_n = 1'b1;
    capture_en = 1'b1;
    repeat (2) step(8'h00, 1'b0, 1'b0);
    chk("idle_capturing", capturing, 0);
    vs_pulse(); exp_fs++; exp_lc = 0;
    chk("active_capturing", capturing, 1);
    line_q = {};
    for (int i = 1; i <= 8; i++) line_q.push_back(8'(i));
    run_line(1'b0, 1'b1);
    chk("t1_w0", exp_q[0], 32'h01020304);
    check_words("t1");
    check_state("t1");
    // 6-byte line: flushed word lands two cycles after DE falls on the pins
    for (int i = 0; i < 6; i++) step(8'hAA + 8'(i), 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_wr_early", bus.word_wr, 0);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_wr_flush", bus.word_wr, 1);
    chk("t2_word_flush", bus.word_out, 32'hAEAF0000);
    repeat (3) step(8'h00, 1'b0, 1'b0);
    chk("t2_word_hold", bus.word_out, 32'hAEAF0000);
    exp_q.push_back(32'hAAABACAD); exp_q.push_back(32'hAEAF0000); exp_lc++;
    check_words("t2");
    rand_line(12); run_line(1'b1, 1'b1);
    check_words("t3_full");
    check_state("t3_full");
    rand_line(5); run_line(1'b0, 1'b1);
    check_words("t3_after");
    check_state("t3_after");
    capture_en = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    capture_en = 1'b1;
    repeat (2) step(8'h00, 1'b0, 1'b0);
    exp_dc = 0; exp_ov = 1'b0;
    check_state("t3_clear");
    chk("t3_capturing", capturing, 1);
    capture_en = 1'b0;
    for (int l = 0; l < 3; l++) begin
      rand_line($urandom_range(1, 13)); run_line(1'b0, 1'b1);
    end
    check_words("t4_lines");
    check_state("t4_lines");
    vs_pulse();
    chk("t4_capturing", capturing, 0);
    rand_line(8); run_line(1'b0, 1'b0);
    check_words("t4_idle");
    check_state("t4_idle");
    capture_en = 1'b1;
    repeat (2) step(8'h00, 1'b0, 1'b0);
    vs_pulse(); exp_fs++; exp_lc = 0;
    step(8'h11, 1'b0, 1'b1); step(8'h22, 1'b0, 1'b1); step(8'h33, 1'b0, 1'b1);
    @(posedge pix_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_word_out", bus.word_out, 0);
    chk("t5_word_wr", bus.word_wr, 0);
    chk("t5_frame_start", frame_start, 0);
    chk("t5_line_count", line_count, 0);
    chk("t5_drop_count", drop_count, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_capturing", capturing, 0);
    bus.vid_de = 1'b0;
    repeat (2) @(negedge pix_clk);
    rst_n = 1'b1;
    repeat (2) step(8'h00, 1'b0, 1'b0);
    vs_pulse(); exp_fs++;
    line_q = {8'h44, 8'h55, 8'h66, 8'h77};
    run_line(1'b0, 1'b1);
    chk("t5_w0", exp_q[0], 32'h44556677);
    check_words("t5");
    check_state("t5");
    step(8'hA1, 1'b0, 1'b1); step(8'hA2, 1'b0, 1'b1);
    step(8'hA3, 1'b1, 1'b1); step(8'hB1, 1'b1, 1'b1);
    step(8'hB2, 1'b0, 1'b1); step(8'hB3, 1'b0, 1'b1); step(8'hB4, 1'b0, 1'b1);
    exp_fs++; exp_lc = 0;
    check_state("t6_restart");
    repeat (6) step(8'h00, 1'b0, 1'b0);
    exp_q.push_back(32'hB1B2B3B4); exp_lc++;
    check_words("t6");
    check_state("t6");
    for (int f = 0; f < 3; f++) begin
      vs_pulse(); exp_fs++; exp_lc = 0;
      for (int l = 0, nl = $urandom_range(2, 5); l < nl; l++) begin
        rand_line($urandom_range(1, 13));
        run_line($urandom_range(0, 3) == 0, 1'b1);
      end
      check_words("rnd");
      check_state("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
